// File: rtl/int_controller_if.sv
// rtl/int_controller_if.sv - bus, interrupt source and CPU handshake bundle for int_controller
interface int_controller_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 8
);
   logic                    we;
   logic [WIDTH-1:0]        addr;
   logic [WIDTH-1:0]        wd;
   logic [WIDTH-1:0]        rd;
   logic [NSRC-1:0]         src;
   logic                    irq;
   logic [$clog2(NSRC)-1:0] irq_vec;
   logic                    irq_ack;

   modport master (output we, addr, wd, src, irq_ack, input rd, irq, irq_vec);
   modport slave  (input we, addr, wd, src, irq_ack, output rd, irq, irq_vec);
endinterface

// File: rtl/int_controller.sv
// rtl/int_controller.sv - prioritised, maskable interrupt controller with edge/level sources
// and a single non-nesting service slot.
module int_controller #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 8,
   parameter int BASE  = 'h8A
) (
   input logic clk,
   input logic rst,
   int_controller_if.slave bus
);
   localparam int VW = $clog2(NSRC);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] REQ     = 2'd1;
   localparam logic [1:0] SERVICE = 2'd2;

   logic [1:0]      state, state_n;
   logic [NSRC-1:0] imr, ipr, icr, isr, src_q, src_qq;
   logic [NSRC-1:0] ipr_n, isr_n, set_vec, active, vec_bit, wd_n;
   logic [VW-1:0]   vec, vec_n, low_idx;
   logic            sel_imr, sel_ipr, sel_icr, sel_isr, sel_eoi;
   logic            ack_take, eoi_take;

   assign sel_imr = (bus.addr == WIDTH'(BASE));
   assign sel_ipr = (bus.addr == WIDTH'(BASE + 1));
   assign sel_icr = (bus.addr == WIDTH'(BASE + 2));
   assign sel_isr = (bus.addr == WIDTH'(BASE + 3));
   assign sel_eoi = (bus.addr == WIDTH'(BASE + 4));
   assign wd_n    = NSRC'(bus.wd);

   // Edge sources raise once per rising edge of src_q; level sources raise every cycle src_q is high.
   assign set_vec = (icr & src_q & ~src_qq) | (~icr & src_q);
   assign active  = ipr & imr;
   assign vec_bit = NSRC'(1) << vec;

   always_comb begin
      low_idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (active[i]) low_idx = VW'(i);
      end
   end

   always_comb begin
      state_n  = state;
      vec_n    = vec;
      ack_take = 1'b0;
      eoi_take = 1'b0;
      case (state)
         IDLE: begin
            if (|active) begin
               state_n = REQ;
               vec_n   = low_idx;
            end
         end
         REQ: begin
            if (bus.irq_ack) begin
               ack_take = 1'b1;
               state_n  = SERVICE;
            end else if (!(|(active & vec_bit))) begin
               state_n = IDLE;
            end
         end
         SERVICE: begin
            if (bus.we && sel_eoi) begin
               eoi_take = 1'b1;
               state_n  = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   // A new request beats a software W1C on the same bit; the acknowledge clear is applied last
   // so a still-high level source re-pends one cycle after the ack.
   always_comb begin
      ipr_n = ipr;
      if (bus.we && sel_ipr) ipr_n = ipr_n & ~wd_n;
      ipr_n = ipr_n | set_vec;
      if (ack_take) ipr_n = ipr_n & ~vec_bit;

      isr_n = isr;
      if (ack_take) isr_n = isr | vec_bit;
      if (eoi_take) isr_n = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         imr    <= '0;
         ipr    <= '0;
         icr    <= '0;
         isr    <= '0;
         src_q  <= '0;
         src_qq <= '0;
         state  <= IDLE;
         vec    <= '0;
      end else begin
         src_q  <= bus.src;
         src_qq <= src_q;
         if (bus.we && sel_imr) imr <= wd_n;
         if (bus.we && sel_icr) icr <= wd_n;
         ipr    <= ipr_n;
         isr    <= isr_n;
         state  <= state_n;
         vec    <= vec_n;
      end
   end

   always_comb begin
      bus.rd = '0;
      if (sel_imr)      bus.rd = WIDTH'(imr);
      else if (sel_ipr) bus.rd = WIDTH'(ipr);
      else if (sel_icr) bus.rd = WIDTH'(icr);
      else if (sel_isr) bus.rd = WIDTH'(isr);
   end

   assign bus.irq     = (state == REQ);
   assign bus.irq_vec = vec;
endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - directed scenarios plus randomized traffic checked against a
// register-level reference model of the interrupt controller.
module tb_int_controller;
   localparam int          WIDTH = 32;
   localparam int          NSRC  = 8;
   localparam int          BASE  = 'h8A;
   localparam int unsigned MASK  = 'hFF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int_controller_if #(.WIDTH(WIDTH), .NSRC(NSRC)) bus ();

   int_controller #(.WIDTH(WIDTH), .NSRC(NSRC), .BASE(BASE)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: phase 0 = waiting, 1 = requesting CPU, 2 = being serviced.
   int unsigned m_imr = 0, m_ipr = 0, m_icr = 0, m_isr = 0, m_sq = 0, m_sqq = 0, m_vec = 0;
   int          m_phase = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int lowest(input int unsigned v);
      for (int i = 0; i < NSRC; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic int unsigned model_rd(input logic [31:0] a);
      int unsigned off;
      off = a - BASE;
      case (off)
         0:       return m_imr;
         1:       return m_ipr;
         2:       return m_icr;
         3:       return m_isr;
         default: return 0;
      endcase
   endfunction

   task automatic model_step();
      int unsigned off, raise, pend, act, bit_v;
      off = bus.addr - BASE;
      if (rst) begin
         m_imr = 0; m_ipr = 0; m_icr = 0; m_isr = 0;
         m_sq = 0; m_sqq = 0; m_vec = 0; m_phase = 0;
      end else begin
         raise = ((m_icr & m_sq & ~m_sqq) | (~m_icr & m_sq)) & MASK;
         pend  = m_ipr;
         if (bus.we && off == 1) pend = pend & ~bus.wd;
         pend  = (pend | raise) & MASK;
         act   = m_ipr & m_imr;
         bit_v = 1 << m_vec;
         case (m_phase)
            0: if (act != 0) begin
                  m_phase = 1;
                  m_vec   = lowest(act);
               end
            1: if (bus.irq_ack) begin
                  pend    = pend & ~bit_v;
                  m_isr   = m_isr | bit_v;
                  m_phase = 2;
               end else if ((act & bit_v) == 0) begin
                  m_phase = 0;
               end
            default: if (bus.we && off == 4) begin
                  m_isr   = 0;
                  m_phase = 0;
               end
         endcase
         if (bus.we && off == 0) m_imr = bus.wd & MASK;
         if (bus.we && off == 2) m_icr = bus.wd & MASK;
         m_ipr = pend;
         m_sqq = m_sq;
         m_sq  = bus.src;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_eq("irq", 32'(bus.irq), 32'(m_phase == 1));
      check_eq("irq_vec", 32'(bus.irq_vec), m_vec);
      check_eq("rd", bus.rd, model_rd(bus.addr));
   endtask

   task automatic peek(input string tag, input int off, input int unsigned exp);
      bus.we   = 1'b0;
      bus.addr = 32'(BASE + off);
      #1;
      check_eq(tag, bus.rd, exp);
   endtask

   task automatic wr(input int off, input int unsigned d);
      bus.we   = 1'b1;
      bus.addr = 32'(BASE + off);
      bus.wd   = d;
      tick();
      bus.we   = 1'b0;
      bus.wd   = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic ack_pulse();
      bus.irq_ack = 1'b1;
      tick();
      bus.irq_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus.we = 1'b0; bus.addr = '0; bus.wd = '0; bus.src = '0; bus.irq_ack = 1'b0;

      // Reset state, unmapped and write-only reads
      do_reset();
      check_eq("rst_irq", 32'(bus.irq), 32'd0);
      peek("rst_imr", 0, 0);
      peek("rst_ipr", 1, 0);
      peek("rst_icr", 2, 0);
      peek("rst_isr", 3, 0);
      peek("eoi_rd", 4, 0);
      peek("unmapped_rd", 5, 0);

      // Edge priority and 2-cycle latency
      wr(0, 'hFFFF_FFFF);
      peek("imr_hi_bits", 0, 'hFF);
      wr(2, 'hFF);
      bus.src = 'h0A;
      tick();
      bus.src = '0;
      tick();
      check_eq("lat_not_yet", 32'(bus.irq), 32'd0);
      peek("prio_ipr", 1, 'h0A);
      tick();
      check_eq("prio_irq", 32'(bus.irq), 32'd1);
      check_eq("prio_vec", 32'(bus.irq_vec), 32'd1);
      ack_pulse();
      check_eq("svc_irq", 32'(bus.irq), 32'd0);
      peek("prio_isr", 3, 'h02);
      peek("prio_ipr2", 1, 'h08);
      wr(4, 0);
      tick();
      check_eq("next_irq", 32'(bus.irq), 32'd1);
      check_eq("next_vec", 32'(bus.irq_vec), 32'd3);
      ack_pulse();
      wr(4, 0);

      // Masking
      do_reset();
      wr(2, 'hFF);
      bus.src = 'h01;
      tick();
      bus.src = '0;
      tick();
      tick();
      peek("mask_ipr", 1, 'h01);
      check_eq("mask_irq", 32'(bus.irq), 32'd0);
      wr(0, 'h01);
      tick();
      check_eq("unmask_irq", 32'(bus.irq), 32'd1);
      check_eq("unmask_vec", 32'(bus.irq_vec), 32'd0);

      // Cancelled request
      do_reset();
      wr(0, 'hFF);
      wr(2, 'hFF);
      bus.src = 'h04;
      tick();
      bus.src = '0;
      tick();
      tick();
      check_eq("cancel_req_vec", 32'(bus.irq_vec), 32'd2);
      wr(1, 'h04);
      tick();
      check_eq("cancel_irq", 32'(bus.irq), 32'd0);
      peek("cancel_isr", 3, 0);

      // Level re-trigger
      do_reset();
      wr(0, 'hFF);
      bus.src = 'h01;
      tick();
      tick();
      tick();
      check_eq("lvl_irq", 32'(bus.irq), 32'd1);
      ack_pulse();
      tick();
      peek("lvl_repend", 1, 'h01);
      wr(4, 0);
      tick();
      check_eq("lvl_reassert", 32'(bus.irq), 32'd1);
      bus.src = '0;

      // Set beats W1C clear
      do_reset();
      wr(2, 'h02);
      bus.src = 'h02;
      tick();
      wr(1, 'h02);
      peek("set_wins", 1, 'h02);
      wr(1, 'h02);
      peek("w1c_clears", 1, 'h00);
      bus.src = '0;

      // Mid-service reset
      do_reset();
      wr(0, 'hFF);
      wr(2, 'hFF);
      bus.src = 'h01;
      tick();
      bus.src = '0;
      tick();
      tick();
      ack_pulse();
      peek("pre_rst_isr", 3, 'h01);
      do_reset();
      check_eq("post_rst_irq", 32'(bus.irq), 32'd0);
      peek("post_rst_imr", 0, 0);
      peek("post_rst_ipr", 1, 0);
      peek("post_rst_icr", 2, 0);
      peek("post_rst_isr", 3, 0);
      wr(0, 'hFF);
      wr(2, 'hFF);
      bus.src = 'h01;
      tick();
      bus.src = '0;
      tick();
      tick();
      check_eq("post_rst_serv", 32'(bus.irq), 32'd1);
      check_eq("post_rst_vec", 32'(bus.irq_vec), 32'd0);

      // Randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         int k;
         rst     = ($urandom_range(0, 199) == 0);
         bus.we  = ($urandom_range(0, 3) == 0);
         k       = $urandom_range(0, 7);
         bus.addr = (k < 6) ? 32'(BASE + k) : ((k == 6) ? 32'd0 : 32'(BASE - 1));
         bus.wd  = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
         bus.src = bus.src ^ 8'($urandom & $urandom & $urandom);
         bus.irq_ack = ($urandom_range(0, 2) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
